// File: rtl/conv_idx_seq_pkg.sv
// Shared types and widths for the convolution index sequencer.
package conv_idx_seq_pkg;

    localparam int unsigned MAX_LEN = 32;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned ZIDX_W  = 6;
    localparam int unsigned SIZE_W  = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_MAC   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_WR    = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/conv_idx_bounds.sv
// Valid input-index window [jlo, jhi] for output index n of an NX x NY convolution.
module conv_idx_bounds
    import conv_idx_seq_pkg::*;
(
    input  logic [ZIDX_W-1:0] n,
    input  logic [SIZE_W-1:0] nx,
    input  logic [SIZE_W-1:0] ny,
    output logic [ADDR_W-1:0] jlo,
    output logic [ADDR_W-1:0] jhi
);

    logic [ZIDX_W:0] n_w;
    logic [ZIDX_W:0] lo_w;
    logic [ZIDX_W:0] hi_w;

    // Compared as n+1 >= NY so the low bound never underflows.
    always_comb begin
        n_w  = {1'b0, n};
        lo_w = '0;
        hi_w = '0;
        if ((n_w + 7'd1) >= {1'b0, ny}) begin
            lo_w = n_w + 7'd1 - {1'b0, ny};
        end
        if (n_w < {1'b0, nx}) begin
            hi_w = n_w;
        end else begin
            hi_w = {1'b0, nx} - 7'd1;
        end
        jlo = ADDR_W'(lo_w);
        jhi = ADDR_W'(hi_w);
    end

endmodule

// File: rtl/conv_idx_seq.sv
// Convolution index sequencer: walks output n and valid input j, driving X/Y reads,
// accumulator strobes and Z writes.
module conv_idx_seq
    import conv_idx_seq_pkg::*;
#(
    parameter int unsigned MAX_LEN = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic [SIZE_W-1:0] size_x_i,
    input  logic [SIZE_W-1:0] size_y_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] x_addr_o,
    output logic [ADDR_W-1:0] y_addr_o,
    output logic              acc_clr_o,
    output logic              acc_en_o,
    output logic [ZIDX_W-1:0] z_addr_o,
    output logic              z_wr_o
);

    state_e            state_q, state_d;
    logic [ZIDX_W-1:0] n_q, n_d;
    logic [ADDR_W-1:0] j_q, j_d;
    logic [ADDR_W-1:0] jhi_q, jhi_d;
    logic [SIZE_W-1:0] nx_q, nx_d, ny_q, ny_d;
    logic [SIZE_W-1:0] sx_sat, sy_sat;
    logic [ADDR_W-1:0] jlo_w, jhi_w;
    logic [ZIDX_W:0]   last_n;
    logic [ZIDX_W-1:0] ysub;
    logic              addr_vld_q;

    logic              busy_d, done_d, clr_d, vld_d, wr_d;
    logic [ADDR_W-1:0] xa_d, ya_d;
    logic [ZIDX_W-1:0] za_d;

    assign sx_sat = (size_x_i > SIZE_W'(MAX_LEN)) ? SIZE_W'(MAX_LEN) : size_x_i;
    assign sy_sat = (size_y_i > SIZE_W'(MAX_LEN)) ? SIZE_W'(MAX_LEN) : size_y_i;
    assign last_n = {1'b0, nx_q} + {1'b0, ny_q} - 7'd2;

    conv_idx_bounds u_bounds (
        .n   (n_q),
        .nx  (nx_q),
        .ny  (ny_q),
        .jlo (jlo_w),
        .jhi (jhi_w)
    );

    // Next state, counters, and the values each output register takes next cycle.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        j_d     = j_q;
        jhi_d   = jhi_q;
        nx_d    = nx_q;
        ny_d    = ny_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    nx_d    = sx_sat;
                    ny_d    = sy_sat;
                    n_d     = '0;
                    state_d = (sx_sat == '0 || sy_sat == '0) ? ST_DONE : ST_CLR;
                end
            end
            ST_CLR: begin
                j_d     = jlo_w;
                jhi_d   = jhi_w;
                state_d = ST_MAC;
            end
            ST_MAC: begin
                if (j_q == jhi_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    j_d = j_q + 5'd1;
                end
            end
            ST_DRAIN: state_d = ST_WR;
            ST_WR: begin
                if ({1'b0, n_q} == last_n) begin
                    state_d = ST_DONE;
                end else begin
                    n_d     = n_q + 6'd1;
                    state_d = ST_CLR;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        clr_d  = (state_d == ST_CLR);
        vld_d  = (state_d == ST_MAC);
        wr_d   = (state_d == ST_WR);
        ysub   = n_d - {1'b0, j_d};
        xa_d   = x_addr_o;
        ya_d   = y_addr_o;
        za_d   = z_addr_o;
        if (state_d == ST_MAC) begin
            xa_d = j_d;
            ya_d = ADDR_W'(ysub);
        end
        if (state_d == ST_WR) begin
            za_d = n_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            j_q        <= '0;
            jhi_q      <= '0;
            nx_q       <= '0;
            ny_q       <= '0;
            addr_vld_q <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            acc_clr_o  <= 1'b0;
            acc_en_o   <= 1'b0;
            z_wr_o     <= 1'b0;
            x_addr_o   <= '0;
            y_addr_o   <= '0;
            z_addr_o   <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            j_q        <= j_d;
            jhi_q      <= jhi_d;
            nx_q       <= nx_d;
            ny_q       <= ny_d;
            addr_vld_q <= vld_d;
            busy_o     <= busy_d;
            done_o     <= done_d;
            acc_clr_o  <= clr_d;
            acc_en_o   <= addr_vld_q;
            z_wr_o     <= wr_d;
            x_addr_o   <= xa_d;
            y_addr_o   <= ya_d;
            z_addr_o   <= za_d;
        end
    end

endmodule

// File: tb/tb_conv_idx_seq.sv
// Scoreboard bench for conv_idx_seq: a reference model fills expectation queues,
// a negedge monitor pops and compares as the DUT emits strobes.
module tb_conv_idx_seq;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start_i;
    logic [5:0] size_x_i, size_y_i;
    logic       busy_o, done_o, acc_clr_o, acc_en_o, z_wr_o;
    logic [4:0] x_addr_o, y_addr_o;
    logic [5:0] z_addr_o;

    conv_idx_seq #(.MAX_LEN(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start_i   (start_i),
        .size_x_i  (size_x_i),
        .size_y_i  (size_y_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .x_addr_o  (x_addr_o),
        .y_addr_o  (y_addr_o),
        .acc_clr_o (acc_clr_o),
        .acc_en_o  (acc_en_o),
        .z_addr_o  (z_addr_o),
        .z_wr_o    (z_wr_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [9:0] exp_xy[$];
    logic [5:0] exp_z[$];
    int         exp_done = 0;
    int         exp_clr  = 0;
    int         clr_seen = 0;
    int         done_evt = 0;
    int         t0       = -100000;
    bit         mon_en   = 1'b0;
    logic [4:0] prev_x   = '0;
    logic [4:0] prev_y   = '0;
    logic [9:0] e_xy;
    logic [5:0] e_z;
    int         rel;
    bit         exp_busy;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: every (j, n-j) pair with both indices in range, one write per n.
    task automatic build(input int sx, input int sy);
        int nx, ny;
        nx = (sx > 32) ? 32 : sx;
        ny = (sy > 32) ? 32 : sy;
        exp_xy.delete();
        exp_z.delete();
        clr_seen = 0;
        if (nx == 0 || ny == 0) begin
            exp_done = 1;
            exp_clr  = 0;
        end else begin
            for (int n = 0; n <= nx + ny - 2; n++) begin
                for (int j = 0; j < nx; j++) begin
                    if (n - j >= 0 && n - j < ny) exp_xy.push_back({5'(j), 5'(n - j)});
                end
                exp_z.push_back(6'(n));
            end
            exp_clr  = nx + ny - 1;
            exp_done = nx * ny + 3 * (nx + ny - 1) + 1;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && rstn) begin
            rel      = cyc - t0;
            exp_busy = (rel >= 1) && (rel <= exp_done);
            chk("busy", longint'(busy_o), longint'(exp_busy));
            if (acc_en_o) begin
                if (exp_xy.size() == 0) chk("acc_en_unexpected", 1, 0);
                else begin
                    e_xy = exp_xy.pop_front();
                    chk("xy_addr", longint'({prev_x, prev_y}), longint'(e_xy));
                end
            end
            if (z_wr_o) begin
                if (exp_z.size() == 0) chk("z_wr_unexpected", 1, 0);
                else begin
                    e_z = exp_z.pop_front();
                    chk("z_addr", longint'(z_addr_o), longint'(e_z));
                end
            end
            if (acc_clr_o) clr_seen++;
            if (done_o) begin
                chk("done_cycle", rel, exp_done);
                chk("xy_left", exp_xy.size(), 0);
                chk("z_left", exp_z.size(), 0);
                chk("clr_count", clr_seen, exp_clr);
                done_evt++;
            end
        end
        prev_x = x_addr_o;
        prev_y = y_addr_o;
    end

    task automatic run(input int sx, input int sy, input bit mid_start);
        int d0, k;
        @(negedge clk);
        build(sx, sy);
        size_x_i = 6'(sx);
        size_y_i = 6'(sy);
        start_i  = 1'b1;
        t0       = cyc;
        d0       = done_evt;
        @(negedge clk);
        start_i  = 1'b0;
        size_x_i = 6'($urandom);
        size_y_i = 6'($urandom);
        if (mid_start) begin
            repeat (3) @(negedge clk);
            start_i = 1'b1;
            @(negedge clk);
            start_i = 1'b0;
        end
        k = 0;
        while (done_evt == d0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (done_evt == d0) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("idle_done", longint'(done_o), 0);
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_busy"}, longint'(busy_o), 0);
        chk({nm, "_done"}, longint'(done_o), 0);
        chk({nm, "_clr"},  longint'(acc_clr_o), 0);
        chk({nm, "_en"},   longint'(acc_en_o), 0);
        chk({nm, "_wr"},   longint'(z_wr_o), 0);
        chk({nm, "_xa"},   longint'(x_addr_o), 0);
        chk({nm, "_ya"},   longint'(y_addr_o), 0);
        chk({nm, "_za"},   longint'(z_addr_o), 0);
    endtask

    initial begin
        rstn     = 1'b0;
        start_i  = 1'b0;
        size_x_i = '0;
        size_y_i = '0;
        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        rstn   = 1'b1;
        mon_en = 1'b1;

        run(1, 1, 1'b0);
        run(3, 2, 1'b0);
        run(32, 32, 1'b0);
        run(0, 5, 1'b0);
        run(40, 1, 1'b0);
        run(4, 3, 1'b1);

        // Abort a run during MAC for n=1, then restart from scratch.
        @(negedge clk);
        build(5, 5);
        size_x_i = 6'd5;
        size_y_i = 6'd5;
        start_i  = 1'b1;
        t0       = cyc;
        @(negedge clk);
        start_i = 1'b0;
        while (cyc - t0 < 7) @(negedge clk);
        mon_en = 1'b0;
        #1;
        chk("pre_abort_busy", longint'(busy_o), 1);
        rstn = 1'b0;
        #1;
        chk_outputs_zero("abort");
        @(negedge clk);
        exp_xy.delete();
        exp_z.delete();
        t0       = -100000;
        exp_done = 0;
        rstn     = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        run(2, 2, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
